// File: rtl/drain_pkg.sv
// Shared types and width helpers for the result_drain output stage.
// Optional build macro DRAIN_COL_MAJOR_EN (see drain_idx_gen) selects emission order.
package drain_pkg;

    typedef enum logic [0:0] {IDLE, STREAM} state_t;

    // $clog2 with a floor of one bit so degenerate sizes still get a real signal
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Width of the linear element index for an n x n matrix
    function automatic int unsigned idx_width(input int unsigned n);
        return clog2_min1(n * n);
    endfunction

endpackage

// File: rtl/drain_idx_gen.sv
// Row/column walker for the drained matrix.
// Build macro DRAIN_COL_MAJOR_EN: defined -> column-major walk, undefined -> row-major.
// The linear index always addresses C[row][col] in the capture layout, so the
// last element is N*N-1 in either order.
module drain_idx_gen
    import drain_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    clear,
    input  logic                    advance,
    output logic [idx_width(N)-1:0] idx,
    output logic                    last
);

    localparam int unsigned IW = idx_width(N);
    localparam int unsigned CW = clog2_min1(N);
    localparam logic [CW-1:0] CMAX = CW'(N - 1);
    localparam logic [IW-1:0] N_IW = IW'(N);

    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;

    // Step the inner counter on each accepted beat, carrying into the outer one
    always_ff @(posedge i_clk) begin
        if (i_rst || clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance) begin
`ifdef DRAIN_COL_MAJOR_EN
            if (row_q == CMAX) begin
                row_q <= '0;
                col_q <= (col_q == CMAX) ? '0 : col_q + CW'(1);
            end else begin
                row_q <= row_q + CW'(1);
            end
`else
            if (col_q == CMAX) begin
                col_q <= '0;
                row_q <= (row_q == CMAX) ? '0 : row_q + CW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
`endif
        end
    end

    assign idx  = IW'(row_q) * N_IW + IW'(col_q);
    assign last = (row_q == CMAX) && (col_q == CMAX);

endmodule

// File: rtl/result_drain.sv
// Output stage behind the systolic array: captures an N x N result matrix in
// one cycle and streams it out as AXI4-Stream beats with TLAST on the final one.
// Build macro DRAIN_COL_MAJOR_EN selects column-major emission order.
module result_drain
    import drain_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              arr_C_valid,
    input  logic [N*N*DW-1:0] arr_C,
    output logic              cap_ready,
    output logic [DW-1:0]     m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic              m_axis_last,
    output logic              o_done
);

    localparam int unsigned IW = idx_width(N);

    state_t            state_q;
    logic [N*N*DW-1:0] cap_q;
    logic [IW-1:0]     idx;
    logic              idx_last;
    logic              capture;
    logic              accept;

    assign capture = (state_q == IDLE) && arr_C_valid;
    assign accept  = m_axis_valid && m_axis_ready;

    drain_idx_gen #(
        .N(N)
    ) u_idx_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (capture),
        .advance(accept),
        .idx    (idx),
        .last   (idx_last)
    );

    // Capture/stream sequencer with registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cap_q        <= '0;
            cap_ready    <= 1'b1;
            m_axis_valid <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arr_C_valid) begin
                        cap_q        <= arr_C;
                        state_q      <= STREAM;
                        cap_ready    <= 1'b0;
                        m_axis_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (accept && idx_last) begin
                        state_q      <= IDLE;
                        cap_ready    <= 1'b1;
                        m_axis_valid <= 1'b0;
                        o_done       <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output element is a mux of registered capture data and index only
    assign m_axis_data = m_axis_valid ? cap_q[int'(idx)*DW +: DW] : '0;
    assign m_axis_last = m_axis_valid && idx_last;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: a small N=2/DW=8 instance for the
// directed frames and an N=4/DW=32 instance for the random-ready frame.
module tb_result_drain;

    localparam int NA = 2, DWA = 8;
    localparam int NB = 4, DWB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_a, cv_a, cr_a, v_a, rdy_a, l_a, done_a;
    logic [NA*NA*DWA-1:0]  c_a;
    logic [DWA-1:0]        dat_a;
    logic                  rst_b, cv_b, cr_b, v_b, rdy_b, l_b, done_b;
    logic [NB*NB*DWB-1:0]  c_b;
    logic [DWB-1:0]        dat_b;

    result_drain #(.N(NA), .DW(DWA)) u_a (
        .i_clk(clk), .i_rst(rst_a), .arr_C_valid(cv_a), .arr_C(c_a),
        .cap_ready(cr_a), .m_axis_data(dat_a), .m_axis_valid(v_a),
        .m_axis_ready(rdy_a), .m_axis_last(l_a), .o_done(done_a)
    );

    result_drain #(.N(NB), .DW(DWB)) u_b (
        .i_clk(clk), .i_rst(rst_b), .arr_C_valid(cv_b), .arr_C(c_b),
        .cap_ready(cr_b), .m_axis_data(dat_b), .m_axis_valid(v_b),
        .m_axis_ready(rdy_b), .m_axis_last(l_b), .o_done(done_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t q_a[$];
    beat_t q_b[$];
    logic  exp_done_a = 1'b0;
    logic  exp_done_b = 1'b0;
    int    beats_b = 0, lasts_b = 0, dones_b = 0;

    // Position r*n+c of the k-th emitted element
    function automatic int elem_pos(input int k, input int n);
        int r, c;
`ifdef DRAIN_COL_MAJOR_EN
        r = k % n;
        c = k / n;
`else
        r = k / n;
        c = k % n;
`endif
        return r * n + c;
    endfunction

    task automatic push_a(input logic [NA*NA*DWA-1:0] m);
        for (int k = 0; k < NA*NA; k++) begin
            beat_t b;
            b.d = 32'(m[elem_pos(k, NA)*DWA +: DWA]);
            b.l = (k == NA*NA-1);
            q_a.push_back(b);
        end
    endtask

    task automatic push_b(input logic [NB*NB*DWB-1:0] m);
        for (int k = 0; k < NB*NB; k++) begin
            beat_t b;
            b.d = m[elem_pos(k, NB)*DWB +: DWB];
            b.l = (k == NB*NB-1);
            q_b.push_back(b);
        end
    endtask

    // Monitor A: compare every presented beat, pop on acceptance, track o_done
    always @(negedge clk) begin
        if (rst_a) begin
            exp_done_a = 1'b0;
        end else begin
            check("a_done", done_a, exp_done_a);
            exp_done_a = 1'b0;
            if (v_a) begin
                if (q_a.size() == 0) begin
                    check("a_extra_beat", v_a, 0);
                end else begin
                    check("a_data", dat_a, q_a[0].d);
                    check("a_last", l_a, q_a[0].l);
                    if (rdy_a) begin
                        if (q_a[0].l) exp_done_a = 1'b1;
                        void'(q_a.pop_front());
                    end
                end
            end
        end
    end

    // Monitor B: same scoreboard plus beat/last/done tallies
    always @(negedge clk) begin
        if (rst_b) begin
            exp_done_b = 1'b0;
        end else begin
            check("b_done", done_b, exp_done_b);
            exp_done_b = 1'b0;
            if (done_b) dones_b++;
            if (v_b) begin
                if (q_b.size() == 0) begin
                    check("b_extra_beat", v_b, 0);
                end else begin
                    check("b_data", dat_b, q_b[0].d);
                    check("b_last", l_b, q_b[0].l);
                    if (rdy_b) begin
                        beats_b++;
                        if (l_b) lasts_b++;
                        if (q_b[0].l) exp_done_b = 1'b1;
                        void'(q_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic drain_a(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (q_a.size() == 0) break;
        end
        check(tag, q_a.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_a();
        logic [NA*NA*DWA-1:0] f1, f2;
        f1 = {8'd22, 8'd21, 8'd12, 8'd11};
        f2 = {8'd4, 8'd3, 8'd2, 8'd1};

        // basic frame, ready held high
        @(posedge clk); #1;
        rdy_a = 1'b1; c_a = f1; cv_a = 1'b1; push_a(f1);
        @(posedge clk); #1;
        cv_a = 1'b0;
        @(negedge clk);
        check("a_first_valid", v_a, 1);
        check("a_first_data", dat_a, 11);
        check("a_first_capready", cr_a, 0);
        repeat (NA*NA-1) begin
            @(negedge clk);
            check("a_no_bubble", v_a, 1);
        end
        @(negedge clk);
        check("a_end_capready", cr_a, 1);
        check("a_end_valid", v_a, 0);
        drain_a("a_basic_drain");

        // backpressure during the second beat
        c_a = f1; cv_a = 1'b1; push_a(f1);
        @(posedge clk); #1;
        cv_a = 1'b0;
        @(posedge clk); #1;
        rdy_a = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("a_bp_data", dat_a, 12);
            check("a_bp_valid", v_a, 1);
            @(posedge clk); #1;
        end
        rdy_a = 1'b1;
        drain_a("a_bp_drain");

        // second matrix offered for the whole first frame
        c_a = f1; cv_a = 1'b1; push_a(f1); push_a(f2);
        @(posedge clk); #1;
        c_a = f2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cr_a) break;
        end
        check("a_blk_capready", cr_a, 1);
        check("a_blk_done_cycle", done_a, 1);
        @(posedge clk); #1;
        cv_a = 1'b0;
        drain_a("a_blk_drain");

        // reset after the second beat is accepted
        c_a = f1; cv_a = 1'b1; push_a(f1);
        @(posedge clk); #1;
        cv_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_a = 1'b1;
        q_a.delete();
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check("a_rst_valid", v_a, 0);
        check("a_rst_capready", cr_a, 1);
        check("a_rst_done", done_a, 0);
        @(posedge clk); #1;
        c_a = f2; cv_a = 1'b1; push_a(f2);
        @(posedge clk); #1;
        cv_a = 1'b0;
        @(negedge clk);
        check("a_post_rst_first", dat_a, 1);
        drain_a("a_post_rst_drain");
    endtask

    task automatic run_b();
        logic [NB*NB*DWB-1:0] m;
        for (int r = 0; r < NB; r++)
            for (int c = 0; c < NB; c++)
                m[(r*NB+c)*DWB +: DWB] = 32'(r*16 + c);
        @(posedge clk); #1;
        c_b = m; cv_b = 1'b1; push_b(m);
        @(posedge clk); #1;
        cv_b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rdy_b = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (q_b.size() == 0) break;
        end
        rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("b_queue_empty", q_b.size(), 0);
        check("b_beats", beats_b, NB*NB);
        check("b_lasts", lasts_b, 1);
        check("b_dones", dones_b, 1);
        check("b_idle_capready", cr_b, 1);
    endtask

    initial begin
        rst_a = 1'b1; cv_a = 1'b0; c_a = '0; rdy_a = 1'b0;
        rst_b = 1'b1; cv_b = 1'b0; c_b = '0; rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("a_rst_cap_ready", cr_a, 1);
        check("a_rst_m_valid", v_a, 0);
        check("a_rst_m_last", l_a, 0);
        check("a_rst_o_done", done_a, 0);
        check("a_rst_m_data", dat_a, 0);
        check("b_rst_cap_ready", cr_b, 1);
        check("b_rst_m_valid", v_b, 0);
        check("b_rst_m_data", dat_b, 0);
        fork
            run_a();
            run_b();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
